keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- 4x4 matrix-keypad scanner: the input-side counterpart of the 4-digit display scan mux.
- Drives one active-low row strobe at a time (same E/D/B/7 one-hot-low pattern the display uses on AN) and samples four active-low column lines.
- Debounces across full scan frames and reports a single clean key code with a one-cycle valid strobe.
- Sits between board keypad pins and the top-level datapath that consumes entered digits.

Parameters:
- SCAN_DIV, 1000, clock cycles each row is held active (dwell); min 2.
- DEBOUNCE, 4, consecutive identical frames needed to accept a press or a release; min 1.
- REPEAT_DELAY, 50, frames held before the first auto-repeat (optional feature only).
- REPEAT_RATE, 10, frames between auto-repeats (optional feature only).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- col_n  input  4  keypad columns, active-low, externally pulled up; asynchronous to clk.
- row_n  output  4  row strobes, one-hot active-low: row0=4'hE, row1=4'hD, row2=4'hB, row3=4'h7.
- row_sel  output  2  index of the currently driven row.
- key_code  output  4  last accepted key = {row[1:0], col[1:0]}.
- key_valid  output  1  one-cycle pulse when a key is accepted.
- key_down  output  1  high from acceptance until the release is accepted.

Behaviour:
- Reset (clk edge with rst_n=0):
  - row_n=4'hE, row_sel=0, dwell counter=0, key_code=0, key_valid=0, key_down=0.
  - FSM=IDLE, debounce/frame counters=0, 2-FF col_n synchronizer filled with 4'hF.
  - Reset mid-press aborts without emitting key_valid.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - On its last count, the synchronized col_n is sampled for the current row; then row_sel increments, wrapping 3->0.
  - row_n = ~(4'b1 << row_sel).
  - One frame = 4*SCAN_DIV cycles, ending at the row-3 sample.
- Frame result:
  - Exactly one column low in exactly one row -> single key, code {row,col}; col index is the position of the 0 bit.
  - Zero keys -> NONE.
  - Two or more low bits in any row, or keys in more than one row -> MULTI, treated as NONE (ghost rejection).
- FSM, evaluated once per frame end:
  - IDLE: single key -> CAND, cand=code, cnt=1; if DEBOUNCE==1, accept immediately as below.
  - CAND, same code -> cnt+1. When cnt reaches DEBOUNCE:
    - key_code<=cand, key_valid=1 for exactly one cycle, key_down<=1, go to PRESSED.
  - CAND, different code or NONE -> IDLE, cnt cleared.
  - PRESSED: NONE -> REL, cnt=1. Same or different key -> stay (no rollover; a second key is ignored until full release).
  - REL: NONE -> cnt+1; at DEBOUNCE go to IDLE and key_down<=0. Any key -> PRESSED, cnt cleared, no new key_valid.
- Latency: key_valid rises 1 cycle after the frame-end sample that completes DEBOUNCE matching frames.
- key_code holds its value after release until the next acceptance.
- Counter widths come from $clog2 of each parameter; no counter wraps within normal use.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in PRESSED, a frame counter starts at acceptance.
  - After REPEAT_DELAY frames of continued press (any key present), key_valid pulses again with unchanged key_code, then every REPEAT_RATE frames.
  - The counter clears on entering REL.
  - Returning from REL to PRESSED restarts the REPEAT_DELAY wait.
- Undefined: exactly one key_valid per press; REPEAT_* parameters are unused.

Test Plan (bench: SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles):
- Reset: rst_n=0 for 3 cycles -> row_n=4'hE, key_code=0, key_valid=0, key_down=0; after release row_n steps E,D,B,7,E every 4 cycles.
- Clean press: model ties col_n[2] low only while row_n=4'hB -> after 3 frames a single key_valid pulse, key_code=4'hA, key_down=1. Release -> key_down=0 exactly 3 frames later; key_code stays 4'hA.
- Bounce: key 5 present 2 frames, absent 1 frame, present 3 frames -> exactly one key_valid, issued after the 3rd consecutive frame.
- Ghosting: keys 0 and 5 held together -> no key_valid, key_down stays 0. Key 0 held and accepted, then key 5 added -> no second pulse.
- Release glitch: PRESSED key 3, one NONE frame, then key 3 again -> key_down stays 1, no extra key_valid.
- KEYPAD_AUTOREPEAT_EN with REPEAT_DELAY=5, REPEAT_RATE=2: hold key 7 for 12 frames after acceptance -> key_valid pulses at acceptance, then +5, +7, +9, +11 frames.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad scanner pin/result bundle.
// master: the scanner (drives rows and key results, reads columns).
// slave:  the board/consumer side (drives columns, reads rows and results).
interface keypad_scan_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [1:0] row_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  col_n,
    output row_n, row_sel, key_code, key_valid, key_down
  );

  modport slave (
    output col_n,
    input  row_n, row_sel, key_code, key_valid, key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one active-low row strobe at a time, 2-FF column
// synchronizer, frame-level ghost rejection, debounce FSM with one-cycle
// key_valid strobe. Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN
// is defined; the default build emits exactly one key_valid per press.
module keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input logic            clk,
  input logic            rst_n,
  keypad_scan_if.master  kp
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_N       = CW'(DEBOUNCE);
  localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_NEXT   = RW'(REPEAT_DELAY + REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_e;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} fres_e;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_sel_q, row_sel_d;
  fres_e         acc_q, acc_d, merged;
  logic [3:0]    acc_code_q, acc_code_d, merged_code;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;

  logic          sample, frame_end, frame_single, accept;
  logic          row_single, row_multi;
  logic [1:0]    col_idx;

  // Row dwell timing and per-row column decode merged into the frame result.
  always_comb begin
    sample    = (dwell_q == DWELL_LAST);
    dwell_d   = sample ? '0 : dwell_q + 1'b1;
    row_sel_d = sample ? row_sel_q + 2'd1 : row_sel_q;
    frame_end = sample && (row_sel_q == 2'd3);

    row_single = 1'b1;
    row_multi  = 1'b0;
    col_idx    = 2'd0;
    case (col_s2_q)
      4'hE:    col_idx = 2'd0;
      4'hD:    col_idx = 2'd1;
      4'hB:    col_idx = 2'd2;
      4'h7:    col_idx = 2'd3;
      4'hF:    row_single = 1'b0;
      default: begin row_single = 1'b0; row_multi = 1'b1; end
    endcase

    // Keys in two rows or two keys in one row are ghost-prone: MULTI.
    merged      = acc_q;
    merged_code = acc_code_q;
    if (row_multi || acc_q == F_MULTI || (row_single && acc_q == F_SINGLE))
      merged = F_MULTI;
    else if (row_single) begin
      merged      = F_SINGLE;
      merged_code = {row_sel_q, col_idx};
    end

    acc_d      = acc_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      acc_d      = frame_end ? F_NONE : merged;
      acc_code_d = merged_code;
    end
    frame_single = frame_end && (merged == F_SINGLE);
  end

  // Debounce / press-release FSM, stepped once per frame end.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    rpt_d       = rpt_q;
    accept      = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    rpt_inc     = rpt_q + 1'b1;

    if (frame_end) begin
      case (state_q)
        IDLE: if (frame_single) begin
          cand_d  = merged_code;
          cnt_d   = CW'(1);
          state_d = CAND;
          accept  = (DEBOUNCE == 1);
        end
        CAND: if (frame_single && merged_code == cand_q) begin
          cnt_d  = cnt_inc;
          accept = (cnt_inc == DB_N);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        PRESSED: if (frame_single) begin
          // Repeat counter cycles between REPEAT_DELAY and REPEAT_DELAY+RATE.
          rpt_d = (rpt_inc == RPT_NEXT) ? RPT_FIRST : rpt_inc;
          key_valid_d = AUTOREPEAT && (rpt_inc == RPT_FIRST || rpt_inc == RPT_NEXT);
        end else begin
          rpt_d = '0;
          if (DEBOUNCE == 1) begin
            state_d    = IDLE;
            cnt_d      = '0;
            key_down_d = 1'b0;
          end else begin
            state_d = REL;
            cnt_d   = CW'(1);
          end
        end
        REL: if (frame_single) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rpt_d   = '0;
        end else if (cnt_inc == DB_N) begin
          state_d    = IDLE;
          cnt_d      = '0;
          key_down_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        state_d     = PRESSED;
        cnt_d       = '0;
        rpt_d       = '0;
        key_code_d  = merged_code;
        key_valid_d = 1'b1;
        key_down_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      dwell_q     <= '0;
      row_sel_q   <= 2'd0;
      acc_q       <= F_NONE;
      acc_code_q  <= 4'h0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      rpt_q       <= '0;
    end else begin
      col_s1_q    <= kp.col_n;
      col_s2_q    <= col_s1_q;
      dwell_q     <= dwell_d;
      row_sel_q   <= row_sel_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      rpt_q       <= rpt_d;
    end
  end

  assign kp.row_n     = ~(4'b0001 << row_sel_q);
  assign kp.row_sel   = row_sel_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  cn;
  int          n_tests = 0;
  int          n_fail = 0;
  int          vld_cnt = 0;
  int          base;

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key pulls its column low while its row is strobed.
  always_comb begin
    cn = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kp.row_n[r]) cn = cn & ~keys[r*4 +: 4];
    kp.col_n = cn;
  end

  // Count key_valid pulses.
  always @(posedge clk)
    if (rst_n && kp.key_valid) vld_cnt = vld_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic reset_hold();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_cycle();
    reset_hold();
    rst_n = 1'b1;
    base = vld_cnt;
  endtask

  logic [3:0] exp_rows [4];
  logic       exp_v;

  initial begin
    exp_rows = '{4'hD, 4'hB, 4'h7, 4'hE};

    // Reset values and row stepping
    keys = '0;
    reset_hold();
    check("rst_row_n", 32'(kp.row_n), 32'hE);
    check("rst_row_sel", 32'(kp.row_sel), 32'h0);
    check("rst_code", 32'(kp.key_code), 32'h0);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_down", 32'(kp.key_down), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("row0", 32'(kp.row_n), 32'hE);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check("row_step", 32'(kp.row_n), 32'(exp_rows[i]));
    end

    // Clean press of key A (row2, col2) and release
    reset_cycle();
    keys = 16'h0400;
    frames(2);
    check("press_early", 32'(vld_cnt - base), 32'h0);
    frames(1);
    check("press_valid", 32'(kp.key_valid), 32'h1);
    check("press_code", 32'(kp.key_code), 32'hA);
    check("press_down", 32'(kp.key_down), 32'h1);
    @(negedge clk);
    check("press_pulse_1cyc", 32'(kp.key_valid), 32'h0);
    repeat (15) @(negedge clk);
    keys = '0;
    frames(2);
    check("rel_down_hold", 32'(kp.key_down), 32'h1);
    frames(1);
    check("rel_down_clr", 32'(kp.key_down), 32'h0);
    check("rel_code_hold", 32'(kp.key_code), 32'hA);
    check("press_count", 32'(vld_cnt - base), 32'h1);

    // Bounce: key 5 present 2, absent 1, present 3 frames
    reset_cycle();
    keys = 16'h0020;
    frames(2);
    keys = '0;
    frames(1);
    keys = 16'h0020;
    frames(2);
    check("bounce_early", 32'(vld_cnt - base), 32'h0);
    frames(1);
    check("bounce_valid", 32'(kp.key_valid), 32'h1);
    check("bounce_code", 32'(kp.key_code), 32'h5);
    frames(2);
    check("bounce_count", 32'(vld_cnt - base), 32'h1);

    // Ghosting: keys in two rows, then two keys in one row
    reset_cycle();
    keys = 16'h0021;
    frames(5);
    check("ghost_rows_cnt", 32'(vld_cnt - base), 32'h0);
    check("ghost_rows_down", 32'(kp.key_down), 32'h0);
    keys = 16'h0003;
    frames(4);
    check("ghost_col_cnt", 32'(vld_cnt - base), 32'h0);

    // Key 0 accepted, then key 5 added: no second pulse
    reset_cycle();
    keys = 16'h0001;
    frames(3);
    check("k0_valid", 32'(kp.key_valid), 32'h1);
    check("k0_code", 32'(kp.key_code), 32'h0);
    keys = 16'h0021;
    frames(5);
    check("k0_add5_cnt", 32'(vld_cnt - base), 32'h1);
    keys = '0;

    // Release glitch on key 3
    reset_cycle();
    keys = 16'h0008;
    frames(4);
    keys = '0;
    frames(1);
    keys = 16'h0008;
    frames(1);
    check("glitch_down", 32'(kp.key_down), 32'h1);
    frames(3);
    check("glitch_down2", 32'(kp.key_down), 32'h1);
    check("glitch_code", 32'(kp.key_code), 32'h3);
    check("glitch_cnt", 32'(vld_cnt - base), 32'h1);

    // Reset during candidate aborts the press
    reset_cycle();
    keys = 16'h8000;
    frames(2);
    reset_hold();
    check("midrst_valid", 32'(kp.key_valid), 32'h0);
    check("midrst_down", 32'(kp.key_down), 32'h0);
    rst_n = 1'b1;
    base = vld_cnt;
    frames(2);
    check("midrst_restart", 32'(vld_cnt - base), 32'h0);
    frames(1);
    check("midrst_valid2", 32'(kp.key_valid), 32'h1);
    check("midrst_code", 32'(kp.key_code), 32'hF);

    // Long hold of key 7: repeats only with auto-repeat built in
    reset_cycle();
    keys = 16'h0080;
    frames(3);
    check("hold_accept", 32'(kp.key_valid), 32'h1);
    check("hold_code", 32'(kp.key_code), 32'h7);
    for (int i = 1; i <= 12; i++) begin
      frames(1);
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_v = (i >= 5) && (i % 2 == 1);
`else
      exp_v = 1'b0;
`endif
      check($sformatf("hold_f%0d", i), 32'(kp.key_valid), 32'(exp_v));
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_count", 32'(vld_cnt - base), 32'h5);
`else
    check("hold_count", 32'(vld_cnt - base), 32'h1);
`endif
    check("hold_code2", 32'(kp.key_code), 32'h7);
    keys = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
